// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronized rising edges of sig_in over a
// fixed GATE_CYCLES window and publishes the count with a one-cycle strobe.
module freq_meter #(
    parameter int GATE_CYCLES = 50000000,
    parameter int CNT_W       = 27,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq,
    output logic             freq_valid,
    output logic             overflow,
    output logic             gate_led
);

    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // Input synchronizer plus one previous-sample flop for edge detection
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   sig_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sig_rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    // Gate timing and edge accumulation
    logic [GW-1:0]    gcnt;
    logic [CNT_W-1:0] ecnt;
    logic             sat;
    logic             terminal;
    logic             at_max;
    logic [CNT_W-1:0] ecnt_nxt;
    logic             sat_hit;

    assign terminal = (gcnt == GATE_LAST);
    assign at_max   = (ecnt == CNT_MAX);

    // Saturation means an edge arrived with nowhere to go, i.e. the count is no
    // longer exact; reaching exactly the max value is still a valid reading.
    always_comb begin
        ecnt_nxt = ecnt;
        sat_hit  = 1'b0;
        if (sig_rise) begin
            if (at_max) sat_hit  = 1'b1;
            else        ecnt_nxt = ecnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gcnt       <= '0;
            ecnt       <= '0;
            sat        <= 1'b0;
            freq       <= '0;
            freq_valid <= 1'b0;
            overflow   <= 1'b0;
            gate_led   <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            if (terminal) begin
                // The terminal cycle's own edge closes out with this window
                gcnt       <= '0;
                freq       <= ecnt_nxt;
                overflow   <= sat | sat_hit;
                freq_valid <= 1'b1;
                gate_led   <= ~gate_led;
                ecnt       <= '0;
                sat        <= 1'b0;
            end else begin
                gcnt <= gcnt + 1'b1;
                ecnt <= ecnt_nxt;
                sat  <= sat | sat_hit;
            end
        end
    end

endmodule
